// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU finish after MULT_LATENCY cycles; DIV/DIVU run a 32-step restoring divider.
module mips_muldiv_unit #(
  parameter int MULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MULT_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] a_mag_in, b_mag;
  logic [32:0] shifted, diff;
  logic [31:0] q_next, r_next;
  logic        q_neg, r_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgn_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      a_q    <= a_d;
      b_q    <= b_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: state_d = S_MUL;
            3'b010, 3'b011: state_d = S_DIV;
            default:        state_d = S_IDLE;
          endcase
        end
      end
      S_MUL:   if (cnt_q == MUL_LAST) state_d = S_IDLE;
      S_DIV:   if (cnt_q == DIV_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed variants (MULT/DIV) have op[0]=0; both share the magnitude/extension logic.
  always_comb begin
    ext_a    = {{32{sgn_q & a_q[31]}}, a_q};
    ext_b    = {{32{sgn_q & b_q[31]}}, b_q};
    prod     = ext_a * ext_b;
    a_mag_in = (~op[0] & operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    b_mag    = (sgn_q & b_q[31]) ? (32'd0 - b_q) : b_q;
    shifted  = {rem_q, quot_q[31]};
    diff     = shifted - {1'b0, b_mag};
    q_next   = {quot_q[30:0], ~diff[32]};
    r_next   = diff[32] ? shifted[31:0] : diff[31:0];
    q_neg    = sgn_q & (a_q[31] ^ b_q[31]);
    r_neg    = sgn_q & a_q[31];
  end

  always_comb begin
    sgn_d  = sgn_q;
    a_d    = a_q;
    b_d    = b_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d  = ~op[0];
          a_d    = operand_a;
          b_d    = operand_b;
          quot_d = a_mag_in;
          rem_d  = '0;
          cnt_d  = '0;
          if (op == 3'b100) begin
            hi_d   = operand_a;
            done_d = 1'b1;
          end else if (op == 3'b101) begin
            lo_d   = operand_a;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end
      end
      S_DIV: begin
        cnt_d  = cnt_q + 5'd1;
        quot_d = q_next;
        rem_d  = r_next;
        if (cnt_q == DIV_LAST) begin
          done_d = 1'b1;
          // Divide-by-zero result is defined on the raw dividend, not the signed fix-up.
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = q_neg ? (32'd0 - q_next) : q_next;
            hi_d = r_neg ? (32'd0 - r_next) : r_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized self-checking bench for mips_muldiv_unit against an arithmetic HI/LO model.
module tb_mips_muldiv_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;
  int exp_done = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mips_muldiv_unit #(.MULT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO after an op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'b000: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = a;
        end else if (o == 3'b010) begin
          sq = sa / sb;
          sr = sa % sb;
          p = 64'(sq); exp_lo = p[31:0];
          p = 64'(sr); exp_hi = p[31:0];
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      3'b100: exp_hi = a;
      3'b101: exp_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; leaves at the negedge where done is visible (back-to-back capable).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_start, input string tag);
    int n, cnt;
    bit hold_ok, early_done;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    model(o, a, b);
    if (o >= 3'b110) begin
      check({tag, "_rsv_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_rsv_done"}, {31'd0, done}, 32'd0);
      check({tag, "_rsv_hi"}, hi, exp_hi);
      check({tag, "_rsv_lo"}, lo, exp_lo);
      return;
    end
    exp_done++;
    if (o >= 3'b100) begin
      check({tag, "_mt_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_mt_done"}, {31'd0, done}, 32'd1);
      check({tag, "_mt_hi"}, hi, exp_hi);
      check({tag, "_mt_lo"}, lo, exp_lo);
      return;
    end
    n = (o <= 3'b001) ? LAT : 32;
    cnt = 0; hold_ok = 1'b1; early_done = 1'b0;
    while (busy && cnt < 40) begin
      cnt++;
      if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
      if (done) early_done = 1'b1;
      if (mid_start && cnt == 2) begin
        start = 1'b1; op = 3'b100; operand_a = $urandom; operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_no_early_done"}, {31'd0, early_done}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic check_done_count(input string tag);
    @(negedge clk);
    #1;
    check(tag, 32'(done_total), 32'(exp_done));
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int r;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult");
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    run_op(3'b011, 32'd7, 32'd2, 1'b0, "divu");
    run_op(3'b011, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1, "div_midmthi");
    check_done_count("done_count_a");

    run_op(3'b100, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi");
    run_op(3'b101, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");
    run_op(3'b110, 32'h1111_1111, 32'd5, 1'b0, "op110");
    run_op(3'b111, 32'h2222_2222, 32'd5, 1'b0, "op111");
    check_done_count("done_count_b");

    // Asynchronous reset ten cycles into a divide.
    start = 1'b1; op = 3'b010; operand_a = 32'd1000; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (35) @(negedge clk);
    check_done_count("arst_no_done");
    run_op(3'b000, 32'h0001_0003, 32'hFFFF_FFFE, 1'b0, "mult_after_rst");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 6);
      o = (r == 6) ? 3'($urandom_range(6, 7)) : 3'(r);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      run_op(o, a, b, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d_op%0d", i, o));
    end
    check_done_count("done_count_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits directly downstream of the register file: its operands are the rs/rt read data (`register_a_data`/`register_b_data`), and it executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The control FSM stalls on `busy`. `hi`/`lo` feed the writeback mux for MFHI/MFLO.

## Interface
- `MULT_LATENCY`, default 1: cycles from accept to result for MULT/MULTU; legal range 1..4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request; sampled on a rising edge only when `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `operand_a`  in  32  rs value (dividend / multiplicand / MTHI-MTLO source).
- `operand_b`  in  32  rt value (divisor / multiplier).
- `busy`  out  1  operation in progress; new `start` ignored.
- `done`  out  1  one-cycle pulse, high in the cycle after HI/LO are updated.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV. Reset state: IDLE.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0. Asserting reset at any time, including mid-operation, aborts the operation and returns all outputs to these values.
- Accept: `start`=1 with `busy`=0 at a rising edge. On accept, `op`, `operand_a` and `operand_b` are latched. Input changes after accept have no effect.
- Reserved op on accept: ignored. No state change, no `done`.
- `start` while `busy`=1: ignored and not queued.
- MTHI: `hi`←`operand_a` at the accept edge; `lo` unchanged. `busy` stays 0; `done`=1 for the next cycle. MTLO is the same, with `lo`←`operand_a` and `hi` unchanged.
- MULT/MULTU: IDLE→MUL. 64-bit product: signed for MULT, unsigned for MULTU. `hi`←product[63:32], `lo`←product[31:0].
- DIV/DIVU: IDLE→DIV. Radix-2 restoring iteration over 32 cycles, one quotient bit per cycle.
  - DIVU: unsigned. `lo`←quotient, `hi`←remainder.
  - DIV: divides the magnitudes, then applies signs. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor = 0 (DIV and DIVU): no trap, still takes 32 cycles. Result `lo`=0xFFFFFFFF, `hi`=`operand_a`.
  - DIV of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `hi`/`lo` change only at result edges, MTHI/MTLO accept edges, and reset. While `busy`=1 they hold their previous values.

## Timing
- Let E0 be the accept edge; N = `MULT_LATENCY` for MUL and N = 32 for DIV.
- `busy`=1 in the cycles after edges E0 .. E0+N−1.
- At edge E0+N: `hi`/`lo` are written, `busy`→0, FSM→IDLE. `done`=1 for exactly the cycle after E0+N.
- A new `start` is accepted at edge E0+N+1 at the earliest, i.e. back-to-back with the `done` cycle.
- MTHI/MTLO: write at E0, `done` in the cycle after E0. A new accept is possible at E0+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- MULT with a=0xFFFFFFFF, b=2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE. In both cases `done` appears exactly `MULT_LATENCY` edges after accept.
- DIV with a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with a=7, b=2 → `lo`=3, `hi`=1. `busy` is high for exactly 32 cycles; `done` is a single-cycle pulse.
- DIVU with a=0x12345678, b=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678. DIV with a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Start a DIV, then during `busy` change the operands and pulse `start` with MTHI → result reflects the latched operands, `hi` is not overwritten by the MTHI, and exactly one `done` occurs.
- Drive `reset` low at cycle 10 of a DIV → `busy`=0, `hi`=`lo`=0 immediately (asynchronous). No `done` follows, and the next MULT completes normally.
- MTHI a=0xDEADBEEF then MTLO a=0xCAFEF00D back-to-back → `hi`=0xDEADBEEF, `lo`=0xCAFEF00D, two `done` pulses, `busy` never asserted; `op`=110 produces no response.
